// File: rtl/wb_master_bridge_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wb_master_bridge_if: request/response channel and Wishbone bus bundle  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface wb_master_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_adr_i;
  logic [3:0]            req_sel_i;
  logic [31:0]           req_dat_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [31:0]           rsp_dat_o;
  logic                  rsp_err_o;
  logic                  rsp_timeout_o;
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [3:0]            wb_sel_o;
  logic [31:0]           wb_dat_o;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_rty_i;
  logic                  wb_stall_i;
  logic [31:0]           wb_dat_i;

  modport master (
    input  req_valid_i, req_we_i, req_adr_i, req_sel_i, req_dat_i, rsp_ready_i,
           wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i,
    output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_adr_i, req_sel_i, req_dat_i, rsp_ready_i,
           wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i,
    input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_master_bridge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | wb_master_bridge: single-transfer Wishbone pipelined initiator with    |
// | retry, timeout and a valid/ready response channel. Revision: 1.0       |
// +------------------------------------------------------------------------+
module wb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3
) (
  input logic                clk_i,
  input logic                rst_i,
  wb_master_bridge_if.master bus
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] C_TMO_MAX   = TW'(TIMEOUT);
  localparam logic [TW-1:0] C_TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] C_MAX_RETRY = RW'(MAX_RETRY);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_STB  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           dat_q, dat_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic                  rsp_tmo_q, rsp_tmo_d;
  logic [31:0]           rsp_dat_q, rsp_dat_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  w_done, w_tmo_hit;

  // Fires in the TIMEOUT-th cycle of an attempt (counter is 0 in the first one).
  assign w_tmo_hit = (TIMEOUT != 0) && (tmo_q == C_TMO_LAST);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    rsp_dat_d   = rsp_dat_q;
    retry_d     = retry_q;
    tmo_d       = tmo_q;
    w_done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          we_d    = bus.req_we_i;
          adr_d   = bus.req_adr_i;
          sel_d   = bus.req_sel_i;
          dat_d   = bus.req_dat_i;
          retry_d = '0;
          tmo_d   = '0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = S_STB;
        end
      end
      S_STB, S_WAIT: begin
        if (tmo_q != C_TMO_MAX) tmo_d = tmo_q + 1'b1;
        if (bus.wb_err_i) begin
          w_done    = 1'b1;
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
        end else if (bus.wb_rty_i) begin
          if (retry_q < C_MAX_RETRY) begin
            retry_d = retry_q + 1'b1;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            state_d = S_GAP;
          end else begin
            w_done    = 1'b1;
            rsp_err_d = 1'b1;
            rsp_dat_d = '0;
          end
        end else if (bus.wb_ack_i) begin
          w_done    = 1'b1;
          rsp_dat_d = we_q ? 32'd0 : bus.wb_dat_i;
        end else if (w_tmo_hit) begin
          w_done    = 1'b1;
          rsp_err_d = 1'b1;
          rsp_tmo_d = 1'b1;
          rsp_dat_d = '0;
        end else if ((state_q == S_STB) && !bus.wb_stall_i) begin
          stb_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_GAP: begin
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        tmo_d   = '0;
        state_d = S_STB;
      end
      S_RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_tmo_d   = 1'b0;
          rsp_dat_d   = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (w_done) begin
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      rsp_valid_d = 1'b1;
      state_d     = S_RESP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      rsp_dat_q   <= '0;
      retry_q     <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
      rsp_dat_q   <= rsp_dat_d;
      retry_q     <= retry_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.req_ready_o   = (state_q == S_IDLE);
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_dat_o     = rsp_dat_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_timeout_o = rsp_tmo_q;
  assign bus.wb_cyc_o      = cyc_q;
  assign bus.wb_stb_o      = stb_q;
  assign bus.wb_we_o       = we_q;
  assign bus.wb_adr_o      = adr_q;
  assign bus.wb_sel_o      = sel_q;
  assign bus.wb_dat_o      = dat_q;
endmodule
`default_nettype wire

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Wishbone pipelined initiator. Turns single-word read/write requests from internal logic into Wishbone cycles toward register-bank responders.
- Issues one transfer at a time and handles stall, ack, err and rty, with a per-attempt timeout and bounded retry.
- Returns read data and status on a valid/ready response channel.

Parameters:
ADDR_WIDTH, 32, width of req_adr_i and wb_adr_o (byte address, passed through unchanged)
TIMEOUT, 255, max cycles per attempt from first stb until termination; 0 disables timeout
MAX_RETRY, 3, number of reissues allowed after rty before failing with error

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active high
req_valid_i  in  1  request present
req_ready_o  out  1  bridge can accept a request
req_we_i  in  1  1 = write, 0 = read
req_adr_i  in  ADDR_WIDTH  byte address
req_sel_i  in  4  byte selects
req_dat_i  in  32  write data
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  consumer takes response
rsp_dat_o  out  32  read data (0 for writes and failures)
rsp_err_o  out  1  transfer failed (err, retries exhausted, or timeout)
rsp_timeout_o  out  1  failure caused by timeout
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_we_o  out  1  write enable
wb_adr_o  out  ADDR_WIDTH  address
wb_sel_o  out  4  byte selects
wb_dat_o  out  32  write data
wb_ack_i  in  1  normal termination
wb_err_i  in  1  error termination
wb_rty_i  in  1  retry termination
wb_stall_i  in  1  responder not accepting strobe
wb_dat_i  in  32  read data

Behaviour:
- All outputs are registered except req_ready_o.
- Reset value of every output: 0, except req_ready_o = 1. Counters and state are cleared; state returns to IDLE.
- Reset mid-transfer: cyc and stb are low the cycle after reset. The pending request and any pending response are discarded.
- FSM states: IDLE, STB, WAIT, GAP, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o at edge N, latch we/adr/sel/dat into wb_* outputs, clear the retry count, and go to STB.
  - wb_cyc_o = wb_stb_o = 1 from cycle N+1.
- STB:
  - cyc = stb = 1.
  - If a termination is sampled, complete (see below). Terminations during stall are legal because responders hold stall until ack.
  - Else if wb_stall_i = 0, drop stb and go to WAIT, keeping cyc = 1.
- WAIT:
  - cyc = 1, stb = 0. Wait for termination.
  - Terminations sampled while cyc = 0 are ignored.
- Termination priority in one cycle: err > rty > ack > timeout.
  - ack: rsp_dat_o = wb_dat_i if read, else 0; rsp_err_o = 0.
  - err: rsp_err_o = 1, rsp_dat_o = 0.
  - rty with retry count < MAX_RETRY: increment retry count, drop cyc/stb, go to GAP. GAP lasts exactly one cycle with cyc = 0, then returns to STB with the same latched request.
  - rty with retry count = MAX_RETRY: rsp_err_o = 1.
  - On every completion: cyc = stb = 0 on the next cycle, rsp_valid_o = 1, go to RESP.
- Timeout:
  - The timeout counter clears on each entry to STB and increments every cycle in STB/WAIT.
  - When the count reaches TIMEOUT with no termination: abort (cyc = stb = 0), rsp_err_o = 1, rsp_timeout_o = 1.
  - A termination in the same cycle as the timeout wins.
  - Counter width is clog2(TIMEOUT+1) and the counter saturates, never wraps.
  - With TIMEOUT = 0 the timeout never fires.
- RESP:
  - rsp_* held stable while rsp_valid_o = 1 & rsp_ready_i = 0.
  - On rsp_ready_i, clear rsp_valid_o/err/timeout next cycle and return to IDLE.
  - req_ready_o = 0 in every state except IDLE, so no new request overlaps an outstanding response.
- Best-case latency with a zero-wait responder (ack with stall = 0 in the first stb cycle): request accepted at edge N, stb high in cycle N+1, rsp_valid_o high in cycle N+2.
- Exactly one strobe accepted per attempt; stb is never re-asserted within one cyc.

Test Plan:
- Read, zero-wait: req adr 0x4, responder acks in the first stb cycle with data 0xDEADBEEF -> one stb cycle, rsp_valid_o at N+2, rsp_dat_o = 0xDEADBEEF, err = 0.
- Write with stall: req we = 1, adr 0x8, dat 0x12345678, sel 0xF; stall held 3 cycles, then ack -> stb high 4 cycles with stable adr/dat/sel; rsp err = 0, dat = 0.
- Retry: responder returns rty twice, then ack -> three stb attempts, each separated by one cyc = 0 cycle; response ok. With rty 4 times and MAX_RETRY = 3 -> 4 attempts, rsp_err_o = 1, rsp_timeout_o = 0.
- Timeout: TIMEOUT = 8, responder never terminates -> cyc drops after 8 cycles; rsp_err_o = 1, rsp_timeout_o = 1. Ack in exactly the 8th cycle -> normal success.
- Backpressure/priority: err and ack in the same cycle -> rsp_err_o = 1. rsp_ready_i low 5 cycles -> response stable, req_ready_o = 0, a new req_valid_i is not accepted.
- Reset mid-WAIT: assert rst_i -> cyc/stb = 0 next cycle, rsp_valid_o = 0, req_ready_o = 1; a later ack is ignored.
